seq_decoder: RTL and testbench
==============================

SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port sym_valid, input, 1 bit: qualifies sym for the current cycle.
REQ-004 The block SHALL have port sym, input, 3 bits: observed octal state symbol from the 264617 sequence FSM.
REQ-005 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of err_count.
REQ-006 The block SHALL have port bit_valid, output, 1 bit: one-cycle pulse; bit_out holds a recovered input bit.
REQ-007 The block SHALL have port bit_out, output, 1 bit: recovered encoder input bit a.
REQ-008 The block SHALL have port byte_valid, output, 1 bit: one-cycle pulse; byte_out is complete.
REQ-009 The block SHALL have port byte_out, output, 8 bits: eight recovered bits, first bit in bit 0.
REQ-010 The block SHALL have port locked, output, 1 bit: tracking is stable.
REQ-011 The block SHALL have port err, output, 1 bit: one-cycle pulse on an illegal symbol or an illegal transition.
REQ-012 The block SHALL have port err_count, output, 8 bits: saturating error count.

Function
REQ-013 Legal codes SHALL be 2, 6, 4, 7 and 1; codes 0, 3 and 5 SHALL be illegal.
REQ-014 Legal transitions SHALL be 2->4, 6->7, 4->6 (a=1), 4->1 (a=0), 7->2 (a=1), 7->4 (a=0) and 1->6; every other pair SHALL be illegal.
REQ-015 The FSM SHALL have states HUNT and TRACK, plus a 3-bit prev register.
REQ-016 In HUNT, a valid legal code SHALL set prev to sym and move to TRACK with no err; a valid illegal code SHALL pulse err and stay in HUNT.
REQ-017 In TRACK with a legal transition, prev SHALL be loaded with sym.
REQ-018 In TRACK with a legal transition from prev=4 or prev=7, bit_valid SHALL pulse with bit_out set to the decoded a.
REQ-019 In TRACK with an illegal transition to a legal code, err SHALL pulse, prev SHALL be loaded with sym (resync), and the block SHALL stay in TRACK.
REQ-020 In TRACK with an illegal code, err SHALL pulse and the block SHALL go to HUNT.
REQ-021 All outputs SHALL be registered and SHALL update on the edge that samples sym (one-cycle latency); pulses SHALL last one cycle.
REQ-022 When sym_valid=0, all state SHALL hold and bit_valid, byte_valid and err SHALL be 0.
REQ-023 A 3-bit good-run counter SHALL increment on each legal TRACK transition and saturate at 3.
REQ-024 locked SHALL be 1 when the good-run counter is 3.
REQ-025 Any err SHALL clear the good-run counter and locked on the same edge.
REQ-026 A shift register SHALL shift each recovered bit in at the MSB and shift right, with a 3-bit bit counter.
REQ-027 On the 8th bit, byte_out SHALL load the completed value, byte_valid SHALL pulse, and the bit counter SHALL wrap to 0.
REQ-028 Any err SHALL discard the partial byte: the bit counter SHALL be set to 0 and byte_out SHALL hold its last value.
REQ-029 err_count SHALL increment on each err and saturate at 255.
REQ-030 When cnt_clr coincides with err, the clear SHALL win and err_count SHALL be 0.

Reset
REQ-031 On reset=0, the FSM SHALL go to HUNT and prev, counters, byte_out and err_count SHALL be 0.
REQ-032 On reset=0, bit_valid, bit_out, byte_valid, locked and err SHALL be 0.
REQ-033 Reset asserted mid-byte or mid-lock SHALL discard all progress immediately.
REQ-034 The first edge after reset deassertion SHALL be processed normally.

Configuration
REQ-035 With macro SEQ_DECODER_BYTE_EN defined, the byte assembler per REQ-026..REQ-028 SHALL be compiled in.
REQ-036 Without SEQ_DECODER_BYTE_EN, byte_valid SHALL be tied 0, byte_out SHALL be tied 0, and no shift register or bit counter SHALL be built.

Verification
REQ-037 The bench SHALL cover: reset release, then valid sym 2,4,6,7,2 -> no err; bit_valid pulses after 6 (bit_out=1) and after 2 (bit_out=1); locked=1 after the 4th symbol.
REQ-038 The bench SHALL cover: sym 2,4,1,6,7,4 -> bit_out 0 after 1, then 0 after the final 4; no err.
REQ-039 The bench SHALL cover: TRACK at prev=2, then sym 6 -> err pulse, prev=6, locked=0, err_count=1; then sym 7 -> no err.
REQ-040 The bench SHALL cover: sym 5 in TRACK -> err pulse, HUNT; then sym 0 -> err; err_count=2.
REQ-041 The bench SHALL cover (SEQ_DECODER_BYTE_EN): a legal stream yielding bits 1,0,1,1,0,0,1,0 -> byte_valid once with byte_out=8'h4D.
REQ-042 The bench SHALL cover: 300 illegal codes -> err_count=255; then cnt_clr with sym 3 -> err_count=0; then reset mid-byte -> all outputs 0.

Source files
------------

// File: rtl/seq_decoder.sv
// Decoder for the 264617 octal state sequence: checks symbol legality, recovers the encoder bit a.
// Optional byte assembler built when SEQ_DECODER_BYTE_EN is defined.
module seq_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       sym_valid,
  input  logic [2:0] sym,
  input  logic       cnt_clr,
  output logic       bit_valid,
  output logic       bit_out,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_count
);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t     state;
  logic [2:0] prev;
  logic [2:0] good;

  logic code_ok;
  logic step_ok;
  logic step_bit;
  logic step_a;
  logic ev_err;
  logic ev_bit;

  // The step_* terms are only meaningful while tracking; they decode the (prev, sym) pair.
  always_comb begin
    code_ok  = (sym == 3'd1) || (sym == 3'd2) || (sym == 3'd4) ||
               (sym == 3'd6) || (sym == 3'd7);
    step_ok  = 1'b0;
    step_bit = 1'b0;
    step_a   = 1'b0;
    case (prev)
      3'd2: step_ok = (sym == 3'd4);
      3'd6: step_ok = (sym == 3'd7);
      3'd1: step_ok = (sym == 3'd6);
      3'd4: begin
        step_ok  = (sym == 3'd6) || (sym == 3'd1);
        step_bit = step_ok;
        step_a   = (sym == 3'd6);
      end
      3'd7: begin
        step_ok  = (sym == 3'd2) || (sym == 3'd4);
        step_bit = step_ok;
        step_a   = (sym == 3'd2);
      end
      default: step_ok = 1'b0;
    endcase
    ev_err = sym_valid && (!code_ok || ((state == TRACK) && !step_ok));
    ev_bit = sym_valid && (state == TRACK) && step_ok && step_bit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      prev      <= 3'd0;
      good      <= 3'd0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      bit_valid <= 1'b0;
      err       <= 1'b0;
      if (sym_valid) begin
        err       <= ev_err;
        bit_valid <= ev_bit;
        if (ev_bit)
          bit_out <= step_a;
        case (state)
          HUNT: begin
            if (code_ok) begin
              prev  <= sym;
              state <= TRACK;
            end
          end
          TRACK: begin
            // A legal code is always adopted as prev, even after a bad transition.
            if (!code_ok)
              state <= HUNT;
            else
              prev <= sym;
          end
          default: state <= HUNT;
        endcase
        if (ev_err) begin
          good   <= 3'd0;
          locked <= 1'b0;
        end else if ((state == TRACK) && step_ok) begin
          if (good != 3'd3)
            good <= good + 3'd1;
          locked <= (good >= 3'd2);
        end
      end
      if (cnt_clr)
        err_count <= 8'd0;
      else if (ev_err && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

`ifdef SEQ_DECODER_BYTE_EN
  logic [7:0] shreg;
  logic [2:0] bcnt;

  // Bits enter at the MSB, so after eight shifts the first bit sits in bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg      <= 8'd0;
      bcnt       <= 3'd0;
      byte_out   <= 8'd0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (ev_err) begin
        bcnt <= 3'd0;
      end else if (ev_bit) begin
        shreg <= {step_a, shreg[7:1]};
        if (bcnt == 3'd7) begin
          byte_out   <= {step_a, shreg[7:1]};
          byte_valid <= 1'b1;
          bcnt       <= 3'd0;
        end else begin
          bcnt <= bcnt + 3'd1;
        end
      end
    end
  end
`else
  assign byte_valid = 1'b0;
  assign byte_out   = 8'd0;
`endif

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder: transition-table model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_seq_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sym_valid = 1'b0;
  logic [2:0] sym = 3'd0;
  logic       cnt_clr = 1'b0;
  logic       bit_valid;
  logic       bit_out;
  logic       byte_valid;
  logic [7:0] byte_out;
  logic       locked;
  logic       err;
  logic [7:0] err_count;

  seq_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .sym_valid  (sym_valid),
    .sym        (sym),
    .cnt_clr    (cnt_clr),
    .bit_valid  (bit_valid),
    .bit_out    (bit_out),
    .byte_valid (byte_valid),
    .byte_out   (byte_out),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef SEQ_DECODER_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  // Transition table: -1 illegal, 2 legal without a bit, 0/1 legal carrying that bit.
  int tbl [8][8];
  initial begin
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        tbl[i][j] = -1;
    tbl[2][4] = 2;
    tbl[6][7] = 2;
    tbl[1][6] = 2;
    tbl[4][6] = 1;
    tbl[4][1] = 0;
    tbl[7][2] = 1;
    tbl[7][4] = 0;
  end

  bit m_track = 0;
  int m_prev = 0;
  int m_good = 0;
  int m_errcnt = 0;
  bit m_bv = 0;
  bit m_bo = 0;
  bit m_byv = 0;
  bit m_err = 0;
  int m_byte = 0;
  int m_t;
  bit m_legal;
  bit bitq[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_track = 0; m_prev = 0; m_good = 0; m_errcnt = 0;
      m_bv = 0; m_bo = 0; m_byv = 0; m_err = 0; m_byte = 0;
      bitq.delete();
    end else begin
      m_bv = 0; m_byv = 0; m_err = 0;
      if (sym_valid) begin
        m_legal = sym inside {3'd1, 3'd2, 3'd4, 3'd6, 3'd7};
        if (!m_track) begin
          if (m_legal) begin
            m_track = 1;
            m_prev  = int'(sym);
          end else begin
            m_err = 1;
          end
        end else if (!m_legal) begin
          m_err   = 1;
          m_track = 0;
        end else begin
          m_t = tbl[m_prev][int'(sym)];
          if (m_t < 0) begin
            m_err = 1;
          end else begin
            m_good = (m_good >= 3) ? 3 : m_good + 1;
            if (m_t != 2) begin
              m_bv = 1;
              m_bo = m_t[0];
              bitq.push_back(m_t[0]);
            end
          end
          m_prev = int'(sym);
        end
        if (m_err) begin
          m_good = 0;
          bitq.delete();
          m_errcnt = (m_errcnt >= 255) ? 255 : m_errcnt + 1;
        end
        if (BYTE_EN && bitq.size() == 8) begin
          m_byte = 0;
          for (int i = 0; i < 8; i++)
            m_byte |= int'(bitq[i]) << i;
          m_byv = 1;
          bitq.delete();
        end
      end
      if (cnt_clr)
        m_errcnt = 0;
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("bit_valid",  bit_valid,  m_bv);
      chk("bit_out",    bit_out,    m_bo);
      chk("byte_valid", byte_valid, m_byv);
      chk("byte_out",   byte_out,   m_byte);
      chk("locked",     locked,     (m_good == 3) ? 1 : 0);
      chk("err",        err,        m_err);
      chk("err_count",  err_count,  m_errcnt);
    end
  end

  task automatic step(input logic v, input logic [2:0] s, input logic c = 1'b0);
    sym_valid = v;
    sym       = s;
    cnt_clr   = c;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    sym_valid = 1'b0;
    cnt_clr   = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  int stream [16] = '{2, 4, 6, 7, 4, 6, 7, 2, 4, 1, 6, 7, 4, 6, 7, 4};

  initial begin
    chk_en = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_locked",    locked,    0);
    chk("rst_err_count", err_count, 0);
    reset = 1'b1;

    // Clean stream 2,4,6,7,2 from reset release
    step(1, 3'd2); chk("first_edge_err", err, 0);
    step(1, 3'd4);
    step(1, 3'd6); chk("b1_valid", bit_valid, 1); chk("b1_out", bit_out, 1);
    step(1, 3'd7); chk("lock_after_4", locked, 1);
    step(1, 3'd2); chk("b2_valid", bit_valid, 1); chk("b2_out", bit_out, 1);
    chk("clean_err_count", err_count, 0);

    // Resync: prev=2 then 6 is a bad transition to a legal code
    step(1, 3'd6); chk("resync_err", err, 1); chk("resync_locked", locked, 0);
    chk("resync_cnt", err_count, 1);
    step(1, 3'd7); chk("resync_follow_err", err, 0);

    // Idle cycles with junk symbols; then cnt_clr alone
    step(0, 3'd3); chk("idle_err", err, 0);
    step(0, 3'd5);
    step(0, 3'd0, 1'b1); chk("clr_idle_cnt", err_count, 0);

    // Stream 2,4,1,6,7,4 yields two zero bits
    do_reset();
    step(1, 3'd2);
    step(1, 3'd4);
    step(1, 3'd1); chk("z1_valid", bit_valid, 1); chk("z1_out", bit_out, 0);
    step(1, 3'd6);
    step(1, 3'd7);
    step(1, 3'd4); chk("z2_valid", bit_valid, 1); chk("z2_out", bit_out, 0);
    chk("z_err", err, 0);

    // Illegal code in TRACK, then illegal in HUNT, then HUNT accepts 6
    do_reset();
    step(1, 3'd2);
    step(1, 3'd5); chk("ill5_err", err, 1);
    step(1, 3'd0); chk("ill0_err", err, 1); chk("ill_cnt", err_count, 2);
    step(1, 3'd6); chk("hunt_accept_err", err, 0);

    // Byte assembly: bits 1,0,1,1,0,0,1,0
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 3'(stream[i]));
    chk("byte_valid_lit", byte_valid, BYTE_EN ? 1 : 0);
    chk("byte_out_lit",   byte_out,   BYTE_EN ? 8'h4D : 8'h00);
    // Partial byte discarded by an error; byte_out must hold
    step(1, 3'd6); step(1, 3'd7); step(1, 3'd2);
    step(1, 3'd7); chk("partial_err", err, 1);
    chk("byte_hold", byte_out, BYTE_EN ? 8'h4D : 8'h00);

    // Saturation and clear priority
    do_reset();
    repeat (300) step(1, 3'd3);
    chk("sat_cnt", err_count, 255);
    step(1, 3'd3, 1'b1); chk("clr_wins_err", err, 1); chk("clr_wins_cnt", err_count, 0);

    // Reset mid-byte and mid-lock
    step(1, 3'd2); step(1, 3'd4); step(1, 3'd6); step(1, 3'd7); step(1, 3'd2);
    chk("pre_rst_locked", locked, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_bit_valid",  bit_valid,  0);
    chk("mid_rst_bit_out",    bit_out,    0);
    chk("mid_rst_byte_valid", byte_valid, 0);
    chk("mid_rst_byte_out",   byte_out,   0);
    chk("mid_rst_locked",     locked,     0);
    chk("mid_rst_err",        err,        0);
    chk("mid_rst_err_count",  err_count,  0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    step(1, 3'd2); chk("post_rst_err", err, 0);
    step(1, 3'd4); chk("post_rst_locked", locked, 0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
